// File: rtl/lcd_glyph_streamer_pkg.sv
// Shared constants and FSM encoding for the LCD glyph streamer.
package lcd_glyph_streamer_pkg;

  localparam int unsigned LCD_NUM_GLYPHS = 16;
  localparam int unsigned LCD_GLYPH_W    = 8;
  localparam int unsigned LCD_SKIP_CNT_W = 3;

  // Blank-cell code of the character writer's font table.
  localparam logic [7:0] FONT_NONE = 8'h20;

  typedef enum logic [1:0] {
    LCD_STAT_IDLE = 2'd0,
    LCD_STAT_LOAD = 2'd1,
    LCD_STAT_SEND = 2'd2,
    LCD_STAT_DONE = 2'd3
  } lcd_state_e;

endpackage

// File: rtl/lcd_glyph_streamer_tick.sv
// Free-running refresh divider: tick is high for one cycle every REFRESH_DIV
// cycles, first in the REFRESH_DIV-th cycle after reset release.
module refresh_tick_gen #(
  parameter int unsigned REFRESH_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [15:0] LAST_CNT = 16'(REFRESH_DIV - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST_CNT);
    cnt_d = tick ? '0 : cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lcd_glyph_streamer.sv
// Snapshots the glyph vector on each refresh tick and streams it slot by slot
// over a valid/ready handshake. Optional LCD_GLYPH_SKIP_UNCHANGED_EN skips unchanged frames.
module lcd_glyph_streamer
  import lcd_glyph_streamer_pkg::*;
#(
  parameter int unsigned NUM_GLYPHS  = LCD_NUM_GLYPHS,
  parameter int unsigned GLYPH_W     = LCD_GLYPH_W,
  parameter int unsigned REFRESH_DIV = 1000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_GLYPHS*GLYPH_W-1:0] data_in,
  input  logic                          glyph_ready,
  output logic                          glyph_valid,
  output logic [GLYPH_W-1:0]            glyph_code,
  output logic [$clog2(NUM_GLYPHS)-1:0] glyph_idx,
  output logic                          frame_start,
  output logic                          frame_done,
  output logic                          busy
);

  localparam int unsigned IDX_W = $clog2(NUM_GLYPHS);
  localparam int unsigned VEC_W = NUM_GLYPHS * GLYPH_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GLYPHS - 1);

  logic tick;

  lcd_state_e       state_q, state_d;
  logic             pending_q, pending_d;
  logic [VEC_W-1:0] snapshot_q, snapshot_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             glyph_valid_q, glyph_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;
`ifdef LCD_GLYPH_SKIP_UNCHANGED_EN
  logic [VEC_W-1:0]          last_sent_q, last_sent_d;
  logic [LCD_SKIP_CNT_W-1:0] skip_cnt_q, skip_cnt_d;
  logic                      force_q, force_d;
  logic                      skip_q, skip_d;
`endif

  refresh_tick_gen #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  always_comb begin
    glyph_code = '0;
    for (int unsigned i = 0; i < NUM_GLYPHS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        glyph_code = snapshot_q[(NUM_GLYPHS-1-i)*GLYPH_W +: GLYPH_W];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    snapshot_d    = snapshot_q;
    idx_d         = idx_q;
    glyph_valid_d = glyph_valid_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    busy_d        = busy_q;
`ifdef LCD_GLYPH_SKIP_UNCHANGED_EN
    last_sent_d   = last_sent_q;
    skip_cnt_d    = skip_cnt_q;
    force_d       = force_q;
    skip_d        = skip_q;
`endif

    if (tick && (state_q != LCD_STAT_IDLE)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      LCD_STAT_IDLE: begin
        if (tick || pending_q) begin
          state_d       = LCD_STAT_LOAD;
          pending_d     = 1'b0;
          busy_d        = 1'b1;
          frame_start_d = 1'b1;
`ifdef LCD_GLYPH_SKIP_UNCHANGED_EN
          // Skip is decided on entry so frame_start can stay a registered output.
          skip_d        = (data_in == last_sent_q) && !force_q;
          frame_start_d = !skip_d;
`endif
        end
      end
      LCD_STAT_LOAD: begin
`ifdef LCD_GLYPH_SKIP_UNCHANGED_EN
        if (skip_q) begin
          state_d    = LCD_STAT_IDLE;
          busy_d     = 1'b0;
          skip_d     = 1'b0;
          skip_cnt_d = skip_cnt_q + 1'b1;
          if (skip_cnt_q == '1) begin
            force_d = 1'b1;
          end
        end else begin
          skip_cnt_d    = '0;
          force_d       = 1'b0;
          snapshot_d    = data_in;
          idx_d         = '0;
          glyph_valid_d = 1'b1;
          state_d       = LCD_STAT_SEND;
        end
`else
        snapshot_d    = data_in;
        idx_d         = '0;
        glyph_valid_d = 1'b1;
        state_d       = LCD_STAT_SEND;
`endif
      end
      LCD_STAT_SEND: begin
        if (glyph_valid_q && glyph_ready) begin
          if (idx_q == LAST_IDX) begin
            glyph_valid_d = 1'b0;
            frame_done_d  = 1'b1;
            state_d       = LCD_STAT_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      LCD_STAT_DONE: begin
        state_d = LCD_STAT_IDLE;
        busy_d  = 1'b0;
`ifdef LCD_GLYPH_SKIP_UNCHANGED_EN
        last_sent_d = snapshot_q;
`endif
      end
      default: begin
        state_d = LCD_STAT_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= LCD_STAT_IDLE;
      pending_q     <= 1'b0;
      snapshot_q    <= '0;
      idx_q         <= '0;
      glyph_valid_q <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
`ifdef LCD_GLYPH_SKIP_UNCHANGED_EN
      last_sent_q   <= '0;
      skip_cnt_q    <= '0;
      force_q       <= 1'b0;
      skip_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      snapshot_q    <= snapshot_d;
      idx_q         <= idx_d;
      glyph_valid_q <= glyph_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
`ifdef LCD_GLYPH_SKIP_UNCHANGED_EN
      last_sent_q   <= last_sent_d;
      skip_cnt_q    <= skip_cnt_d;
      force_q       <= force_d;
      skip_q        <= skip_d;
`endif
    end
  end

  assign glyph_valid = glyph_valid_q;
  assign glyph_idx   = idx_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;

endmodule

// File: doc/lcd_glyph_streamer.md
Name: lcd_glyph_streamer

Overview:
- Downstream consumer of the result/game screen generators' 128-bit glyph vector: 16 slots × 8-bit font/graph codes.
- Periodically snapshots the vector and streams it one glyph per handshake to the LCD character writer, which holds the font ROM and bus timing.
- Snapshotting removes tearing when the screen source changes mid-frame.

Parameters:
- NUM_GLYPHS, 16, glyph slots per frame (idx width = 4).
- GLYPH_W, 8, bits per glyph code.
- REFRESH_DIV, 1000, clk cycles between refresh ticks; legal range is 2 to 65535.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  128  glyph vector; slot 0 = data_in[127:120], slot 15 = data_in[7:0].
- glyph_ready  input  1  downstream writer accepts glyph this cycle.
- glyph_valid  output  1  glyph_code/glyph_idx are valid.
- glyph_code  output  8  current glyph code.
- glyph_idx  output  4  slot index of glyph_code.
- frame_start  output  1  one-cycle pulse in the LOAD cycle.
- frame_done  output  1  one-cycle pulse after the last glyph is accepted.
- busy  output  1  high in LOAD, SEND and DONE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; refresh counter=0; pending=0; snapshot=0; idx=0.
  - All outputs 0.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick=1 in the cycle the count equals REFRESH_DIV-1.
  - The first tick occurs REFRESH_DIV cycles after reset release.
- pending flag:
  - Set by a tick while busy.
  - Cleared on entering LOAD.
  - One-deep: extra ticks while pending=1 are dropped.
- FSM states and transitions:
  - IDLE → LOAD on tick or pending.
  - LOAD, 1 cycle: snapshot <= data_in; idx <= 0; frame_start=1; next state SEND.
  - SEND: glyph_valid=1; glyph_code=snapshot slot idx; glyph_idx=idx.
    - Transfer when glyph_valid && glyph_ready.
    - On transfer with idx<NUM_GLYPHS-1: idx++, stay in SEND.
    - On transfer with idx==NUM_GLYPHS-1: go to DONE.
  - DONE, 1 cycle: frame_done=1; glyph_valid=0; next state IDLE. If pending=1, IDLE goes to LOAD on the next cycle.
- Handshake rules:
  - Once glyph_valid is asserted, glyph_code and glyph_idx stay stable until the transfer.
  - glyph_valid never drops without a transfer, except on reset.
  - glyph_ready is ignored outside SEND.
- Latency and throughput:
  - Minimum frame = 1 (LOAD) + 16 (SEND with ready held high) + 1 (DONE) = 18 cycles.
  - data_in changes after LOAD do not affect the current frame.
- Simultaneous tick in the LOAD or DONE cycle: sets pending.
- Reset mid-SEND: immediate abort to IDLE with all outputs 0. No frame_done for the aborted frame.
- glyph_ready held low indefinitely: the block stalls in SEND. Ticks during the stall collapse into a single pending.
- Outputs are registered, except glyph_code, which is a mux of the registered snapshot and registered idx.

Optional Feature:
- Macro: LCD_GLYPH_SKIP_UNCHANGED_EN.
- When defined:
  - Keep a last_sent register (128 bits, reset 0), updated in DONE with the snapshot.
  - In LOAD, if data_in == last_sent and a forced frame is not due, go straight to IDLE with no frame_start, no glyphs and no frame_done. busy is high for that single cycle only.
  - A forced frame is due after every 8th consecutive skip (3-bit skip counter, reset 0, cleared on every sent frame). This tolerates LCD corruption.
  - The first frame after reset is always sent if data_in != 0; an all-zero screen is skipped until forced.
- When undefined: every tick sends a full frame.

Decomposition:
- global.v (shared defines):
  - LCD_NUM_GLYPHS=16 and LCD_GLYPH_W=8.
  - State encodings LCD_STAT_IDLE/LOAD/SEND/DONE (2-bit).
  - Reuse the existing FONT_NONE define in benches.
- One sub-module: refresh_tick_gen.
  - Parameterised by REFRESH_DIV.
  - Ports: clk, rst_n, tick.
  - Async active-low reset.

Test Plan:
- Reset, REFRESH_DIV=20, data_in=16×FONT_NONE, ready=1: frame_start at cycle 20 after reset release, 16 transfers idx 0..15 each with code FONT_NONE, frame_done at cycle 37, busy low at cycle 38.
- data_in slot i = 8'h30+i, ready toggling 1/0 every cycle: codes 8'h30..8'h3F in order; code and idx held stable on every ready=0 cycle; 31 SEND cycles total.
- Change data_in to all 8'hAA at the 5th transfer: remainder of the frame still sends the original slots 5..15; the next frame sends 8'hAA.
- ready=0 for 3×REFRESH_DIV cycles in SEND, then ready=1: frame completes, exactly one extra frame follows immediately (pending), then normal period resumes.
- rst_n pulsed low mid-SEND at idx=7: all outputs 0 in the same cycle (async); next frame starts REFRESH_DIV cycles after release and restarts at idx 0.
- With LCD_GLYPH_SKIP_UNCHANGED_EN, constant non-zero data_in: frame 1 is sent, ticks 2–9 are skipped (no frame_start), tick 10 sends a forced frame; changing a single slot sends a frame on the next tick.
